// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: two-port round-robin arbiter in front of a single I2C master.
// A winning requester's op/addr/wdata are latched and handed to the master,
// the master's completion is routed back as a one-cycle ack with err/rdata.
// Optional build macro I2C_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog that
// aborts with err=1 after TIMEOUT cycles without m_done.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no owner; pick a winner when the master is free
// ISSUE     | owner granted, request latched; m_start fires on leaving
// WAIT_DONE | waiting for m_done (or the watchdog, when enabled)
// RESPOND   | ack/err/rdata visible; grant cleared and last owner recorded
module i2c_bus_arbiter #(
  parameter int unsigned TIMEOUT = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       op0,
  input  logic       op1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [1:0] grant,
  output logic       m_start,
  output logic       m_op,
  output logic [6:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic       m_ack_err,
  input  logic [7:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;        // 1: port 1 was served last
  logic       m_start_q, m_start_d;
  logic       m_op_q, m_op_d;
  logic [6:0] m_addr_q, m_addr_d;
  logic [7:0] m_wdata_q, m_wdata_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       err0_q, err0_d;
  logic       err1_q, err1_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic       pick1;
  logic       timeout_hit;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Watchdog counts WAIT_DONE cycles; it reads zero on the first WAIT_DONE cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT_DONE) cnt_d = cnt_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_hit = (state_q == WAIT_DONE) && (cnt_q == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Round-robin choice: on a tie, the port not served last wins.
  always_comb begin
    pick1 = req1;
    if (req0 && req1) pick1 = ~last_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    m_start_d = 1'b0;
    m_op_d    = m_op_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    case (state_q)
      IDLE: begin
        if (!m_busy && (req0 || req1)) begin
          grant_d   = pick1 ? 2'b10 : 2'b01;
          m_op_d    = pick1 ? op1 : op0;
          m_addr_d  = pick1 ? addr1 : addr0;
          m_wdata_d = pick1 ? wdata1 : wdata0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        m_start_d = 1'b1;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (m_done) begin
          state_d = RESPOND;
          if (grant_q[1]) begin
            ack1_d = 1'b1;
            err1_d = m_ack_err;
            if (m_op_q) rdata1_d = m_rdata;
          end else begin
            ack0_d = 1'b1;
            err0_d = m_ack_err;
            if (m_op_q) rdata0_d = m_rdata;
          end
        end else if (timeout_hit) begin
          // Abort: report an error, leave the read data untouched.
          state_d = RESPOND;
          if (grant_q[1]) begin
            ack1_d = 1'b1;
            err1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
            err0_d = 1'b1;
          end
        end
      end
      RESPOND: begin
        grant_d = 2'b00;
        last_d  = grant_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset primes last_q so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      m_start_q <= 1'b0;
      m_op_q    <= 1'b0;
      m_addr_q  <= 7'd0;
      m_wdata_q <= 8'd0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 8'd0;
      rdata1_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      m_start_q <= m_start_d;
      m_op_q    <= m_op_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign grant   = grant_q;
  assign m_start = m_start_q;
  assign m_op    = m_op_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

  // Structural invariants: single owner, single ack, a usable watchdog length.
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) grant_q != 2'b11);
  a_ack_excl:     assert property (@(posedge clk) disable iff (rst) !(ack0_q && ack1_q));
  a_timeout_len:  assert property (@(posedge clk) disable iff (rst) TIMEOUT > 1);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed transactions with an ack scoreboard.
module tb_i2c_bus_arbiter;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TB_TO = 16;
`else
  localparam int unsigned TB_TO = 40000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, op0, op1;
  logic [6:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic [1:0] grant;
  logic       m_start, m_op;
  logic [6:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_busy, m_done, m_ack_err;
  logic [7:0] m_rdata;

  typedef struct {
    int port;
    int err;
    int rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   ack_cnt = 0;
  logic [7:0] rd_model [2];

  i2c_bus_arbiter #(.TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .grant(grant),
    .m_start(m_start), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err), .m_rdata(m_rdata)
  );

  always #4 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every ack pops one expected response.
  always @(negedge clk) begin
    if (!rst && (ack0 || ack1)) begin
      ack_cnt++;
      chk("ack_excl", int'(ack0 & ack1), 0);
      if (exp_q.size() == 0) begin
        chk("ack_unexp", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_port", ack1 ? 1 : 0, mon_e.port);
        chk("ack_err", int'(ack1 ? err1 : err0), mon_e.err);
        chk("ack_rdata", int'(ack1 ? rdata1 : rdata0), mon_e.rdata);
      end
    end
  end

  task automatic push_exp(input int p, input int e, input int r);
    exp_t x;
    x.port = p; x.err = e; x.rdata = r;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    m_busy = 0; m_done = 0; m_ack_err = 0; m_rdata = 0;
    rd_model[0] = 8'h00; rd_model[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One-cycle m_done; returns 1 time unit after the edge that should raise ack.
  task automatic pulse_done(input logic [7:0] rd, input logic ae);
    @(posedge clk); #1;
    m_done = 1'b1; m_rdata = rd; m_ack_err = ae;
    @(posedge clk); #1;
    m_done = 1'b0; m_rdata = 8'h00; m_ack_err = 1'b0;
  endtask

  task automatic set_port(input int p, input logic rq, input logic op,
                          input logic [6:0] a, input logic [7:0] wd);
    if (p == 0) begin req0 = rq; op0 = op; addr0 = a; wdata0 = wd; end
    else        begin req1 = rq; op1 = op; addr1 = a; wdata1 = wd; end
  endtask

  // Full single-port transaction with hold/stability and ack timing checks.
  task automatic txn(input int p, input logic op, input logic [6:0] a,
                     input logic [7:0] wd, input logic [7:0] rd, input logic ae);
    logic ok;
    int   n0;
    @(posedge clk); #1;
    set_port(p, 1'b1, op, a, wd);
    wait_start(ok);
    chk("start_seen", int'(ok), 1);
    chk("txn_grant", int'(grant), (p == 1) ? 2 : 1);
    chk("txn_addr", int'(m_addr), int'(a));
    chk("txn_op", int'(m_op), int'(op));
    chk("txn_wdata", int'(m_wdata), int'(wd));
    push_exp(p, int'(ae), op ? int'(rd) : int'(rd_model[p]));
    if (op) rd_model[p] = rd;
    @(posedge clk); #1;
    set_port(p, 1'b0, ~op, a ^ 7'h7f, wd ^ 8'hff);
    @(negedge clk);
    chk("start_pulse", int'(m_start), 0);
    repeat (2) @(negedge clk);
    chk("hold_addr", int'(m_addr), int'(a));
    chk("hold_op", int'(m_op), int'(op));
    chk("hold_wdata", int'(m_wdata), int'(wd));
    n0 = ack_cnt;
    pulse_done(rd, ae);
    chk("ack_lat", int'((p == 1) ? ack1 : ack0), 1);
    @(posedge clk); #1;
    chk("ack_once", int'(ack0 | ack1), 0);
    chk("grant_clr", int'(grant), 0);
    chk("ack_count", ack_cnt, n0 + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   n0, bad, k;

    rst = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_start", int'(m_start), 0);
    chk("rst_maddr", int'(m_addr), 0);
    chk("rst_mop", int'(m_op), 0);
    chk("rst_mwdata", int'(m_wdata), 0);
    chk("rst_ack", int'({ack0, ack1, err0, err1}), 0);
    chk("rst_rdata", int'({rdata0, rdata1}), 0);

    // Single read on port 0.
    txn(0, 1'b1, 7'h25, 8'h00, 8'hA5, 1'b0);
    chk("rd0_hold", int'(rdata0), 8'hA5);

    // Port 1 read then NACKed write: rdata1 must survive the write.
    txn(1, 1'b1, 7'h51, 8'h00, 8'h5A, 1'b0);
    txn(1, 1'b0, 7'h42, 8'h3C, 8'hC3, 1'b1);
    chk("rd1_hold", int'(rdata1), 8'h5A);

    // m_done while idle is ignored.
    n0 = ack_cnt;
    pulse_done(8'h11, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_idle_ign", ack_cnt, n0);
    chk("done_idle_grant", int'(grant), 0);

    // Busy hold-off, plus m_done during ISSUE ignored.
    @(posedge clk); #1;
    m_busy = 1'b1;
    set_port(0, 1'b1, 1'b0, 7'h11, 8'h99);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (grant != 2'b00) bad++;
    end
    chk("busy_hold", bad, 0);
    @(posedge clk); #1 m_busy = 1'b0;
    @(negedge clk);
    chk("busy_g0", int'(grant), 0);
    @(posedge clk); #1 m_done = 1'b1;
    @(negedge clk);
    chk("busy_g1", int'(grant), 1);
    @(posedge clk); #1 m_done = 1'b0;
    @(negedge clk);
    chk("busy_start", int'(m_start), 1);
    n0 = ack_cnt;
    repeat (4) @(negedge clk);
    chk("done_issue_ign", ack_cnt, n0);
    push_exp(0, 0, int'(rd_model[0]));
    pulse_done(8'h00, 1'b0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_ack", ack_cnt, n0 + 1);

    // Three-way tie from reset: 01, 10, 01.
    do_reset();
    set_port(0, 1'b1, 1'b0, 7'h10, 8'h01);
    set_port(1, 1'b1, 1'b0, 7'h20, 8'h02);
    for (int i = 0; i < 3; i++) begin
      wait_start(ok);
      chk("tie_start", int'(ok), 1);
      chk("tie_grant", int'(grant), (i == 1) ? 2 : 1);
      push_exp((i == 1) ? 1 : 0, 0, 0);
      pulse_done(8'h00, 1'b0);
      if (i == 2) begin req0 = 1'b0; req1 = 1'b0; end
    end
    repeat (3) @(negedge clk);
    chk("tie_idle", int'(grant), 0);

    // Reset while in WAIT_DONE drops the transaction and restores tie order.
    txn(0, 1'b1, 7'h2A, 8'h00, 8'h77, 1'b0);
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b1, 7'h33, 8'h44);
    wait_start(ok);
    chk("rstw_start", int'(ok), 1);
    do_reset();
    n0 = ack_cnt;
    pulse_done(8'hEE, 1'b0);
    repeat (3) @(negedge clk);
    chk("rstw_noack", ack_cnt, n0);
    chk("rstw_rdata", int'({rdata0, rdata1}), 0);
    chk("rstw_grant", int'(grant), 0);
    chk("rstw_master", int'({m_start, m_op, m_addr, m_wdata}), 0);
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 7'h05, 8'h06);
    set_port(1, 1'b1, 1'b0, 7'h07, 8'h08);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_tie", int'(grant), 1);
    @(posedge clk); #1 req1 = 1'b0;
    wait_start(ok);
    chk("rstw_start2", int'(ok), 1);
    push_exp(0, 0, 0);
    pulse_done(8'h00, 1'b0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    // Watchdog behaviour.
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b1, 7'h3F, 8'h00);
    wait_start(ok);
    chk("to_start", int'(ok), 1);
    @(posedge clk); #1 req0 = 1'b0;
    n0 = ack_cnt;
`ifdef I2C_ARB_TIMEOUT_EN
    push_exp(0, 1, int'(rd_model[0]));
    k = 1;
    while (!ack0 && k < 40) begin
      @(negedge clk);
      if (!ack0) k++;
    end
    chk("to_cycles", k, 16);
    repeat (2) @(negedge clk);
    chk("to_ack", ack_cnt, n0 + 1);
`else
    k = 0;
    repeat (1000) @(negedge clk);
    chk("no_to_ack", ack_cnt, n0);
    chk("no_to_grant", int'(grant), 1);
    do_reset();
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter TIMEOUT, default 40000, is the clk cycles allowed from m_start to m_done before an abort; it is used only under REQ-021.
REQ-003 The block SHALL have the following ports:
- clk  in  1  system clock, 125 MHz
- rst  in  1  async active-high reset
- req0 / req1  in  1  transaction request, level; held until the matching ack
- op0 / op1  in  1  1 = read, 0 = write
- addr0 / addr1  in  7  target slave address
- wdata0 / wdata1  in  8  write byte
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  error flag, valid only while the matching ack is high
- rdata0 / rdata1  out  8  last read byte; holds its value between reads
- grant  out  2  one-hot owner of the master; 00 when idle
- m_start  out  1  one-cycle start pulse to the I2C master
- m_op  out  1  registered op for the master
- m_addr  out  7  registered address for the master
- m_wdata  out  8  registered write byte for the master
- m_busy  in  1  master busy
- m_done  in  1  master completion pulse
- m_ack_err  in  1  master NACK flag, sampled with m_done
- m_rdata  in  8  master read byte, sampled with m_done

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, WAIT_DONE and RESPOND.
REQ-005 IDLE: when m_busy=0 and at least one req is high, the block SHALL choose a winner, latch its op/addr/wdata into m_op/m_addr/m_wdata, set grant, and go to ISSUE on the next edge.
REQ-006 IDLE with m_busy=1: the block SHALL issue no grant and remain in IDLE, whatever the requests.
REQ-007 Tie (req0 and req1 both high in the same cycle): the winner SHALL be the requester not served last, tracked by a last_grant register (round-robin).
REQ-008 ISSUE: m_start SHALL be high for exactly one cycle, the cycle after grant is set, and the next state SHALL be WAIT_DONE.
REQ-009 WAIT_DONE: m_done SHALL be honoured only in this state; on m_done, the block SHALL capture m_ack_err and, when m_op=1, m_rdata, then go to RESPOND.
REQ-010 m_done seen in IDLE, ISSUE or RESPOND SHALL be ignored.
REQ-011 RESPOND: ackN SHALL pulse for one cycle, with errN equal to the captured m_ack_err.
REQ-012 RESPOND: on a read, rdataN SHALL be updated on the same edge the ack is set; on a write, rdataN is unchanged.
REQ-013 RESPOND: grant SHALL clear to 00 and last_grant SHALL update; the next state SHALL be IDLE.
REQ-014 Latency: ackN SHALL rise exactly 1 cycle after the m_done cycle; grant SHALL rise 1 cycle after a qualifying req is seen in IDLE.
REQ-015 A req dropped mid-transaction SHALL NOT abort the transaction; the ack still pulses.
REQ-016 A req still high in the cycle after its ack SHALL be treated as a new request, subject to round-robin.
REQ-017 m_op, m_addr and m_wdata SHALL stay stable from grant until RESPOND, irrespective of changes on the requester inputs.
REQ-018 Both ack outputs SHALL NOT be high in the same cycle, and grant SHALL never be 11.

Reset
REQ-019 On rst, the block SHALL force state to IDLE and set to 0: grant, all ack, err and rdata outputs, m_start, m_op, m_addr, m_wdata and the timeout counter.
REQ-020 On rst, last_grant SHALL be set so that req0 wins the first tie; a transaction in flight SHALL be dropped with no ack.

Configuration
REQ-021 With macro I2C_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_DONE. When it reaches TIMEOUT-1 without m_done, the FSM SHALL go to RESPOND with errN=1 and rdataN unchanged. The counter SHALL clear on entry to WAIT_DONE.
REQ-022 Without I2C_ARB_TIMEOUT_EN, no counter SHALL be instantiated and WAIT_DONE SHALL wait for m_done indefinitely.

Verification
REQ-023 Single read: req0=1, op0=1, addr0=0x25; m_done with m_rdata=0xA5, m_ack_err=0 -> m_start pulses once with m_addr=0x25; ack0 pulses 1 cycle after m_done; rdata0=0xA5; err0=0.
REQ-024 Tie: req0 and req1 both held for three transactions from reset -> grant sequence 01, 10, 01; ack0, ack1, ack0 in that order.
REQ-025 NACK: write from port 1, wdata1=0x3C, m_ack_err=1 at m_done -> err1=1 during the ack1 pulse; rdata1 unchanged.
REQ-026 Busy hold-off: m_busy=1 with req0=1 for 50 cycles -> grant=00 throughout; after m_busy falls, grant=01 on the next cycle.
REQ-027 Reset in WAIT_DONE, then m_done -> no ack; all outputs 0; the next tie is won by req0.
REQ-028 With I2C_ARB_TIMEOUT_EN and TIMEOUT=16, no m_done -> ack0 with err0=1 16 cycles after entry to WAIT_DONE; without the macro, no ack after 1000 cycles.
